dma_out_sched: RTL and testbench

DMA_OUT_SCHED -- requirements
Module: dma_out_sched

---
 rtl/dma_out_sched.sv | 179 +++++++++++++++++
 tb/tb_dma_out_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_out_sched.sv
// -----------------------------------------------------------------------------
// dma_out_sched
//   Round-robin scheduler that picks which PE hands its next buffered packet to
//   the DMA output engine. Each PE has a pending-packet counter; the FSM offers
//   a one-hot grant, waits for the engine to accept it, then tracks the packet
//   in flight until the engine reports the tail or a watchdog aborts it.
//
// Ports
//   i_clk, i_rst_n   clock / asynchronous active-low reset
//   i_pkt_in         per-PE pulse: one more packet fully buffered
//   i_pe_en          per-PE grant enable (counting continues when clear)
//   o_grant_valid    a grant is offered
//   o_grant          one-hot PE selection, zero when no grant is offered
//   i_grant_ready    output engine accepts the offered grant
//   i_pkt_done       output engine emitted the tail of the granted packet
//   o_busy           a granted packet is in flight
//   o_timeout        one-cycle pulse when the in-flight packet is aborted
//   o_ovf            sticky per-PE counter overflow flags
//   o_err            sticky flag: i_pkt_done seen while nothing was in flight
//   d_state_2b       current FSM state (debug)
// -----------------------------------------------------------------------------
module dma_out_sched #(
    parameter int NUM_PE  = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_PE-1:0] i_pkt_in,
    input  logic [NUM_PE-1:0] i_pe_en,
    output logic              o_grant_valid,
    output logic [NUM_PE-1:0] o_grant,
    input  logic              i_grant_ready,
    input  logic              i_pkt_done,
    output logic              o_busy,
    output logic              o_timeout,
    output logic [NUM_PE-1:0] o_ovf,
    output logic              o_err,
    output logic [1:0]        d_state_2b
);

    localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [PTR_W-1:0] LAST_PE   = PTR_W'(NUM_PE - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [NUM_PE];
    logic [CNT_W-1:0]  cnt_d [NUM_PE];
    logic [NUM_PE-1:0] ovf_q, ovf_d;
    logic [NUM_PE-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  win_q, win_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic              timeout_q, timeout_d;
    logic              err_q, err_d;

    logic              hs;
    logic              found;
    logic [PTR_W-1:0]  win_idx;
    int                scan_idx;

    assign hs = (state_q == GRANT) && i_grant_ready;

    // Round-robin search: first eligible PE at or above rr_ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_PE; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_PE) scan_idx = scan_idx - NUM_PE;
            if (!found && i_pe_en[scan_idx] && (cnt_q[scan_idx] != '0)) begin
                found   = 1'b1;
                win_idx = PTR_W'(scan_idx);
            end
        end
    end

    // Pending-packet counters. Simultaneous arrival and grant cancel out, so a
    // saturated counter only flags overflow when nothing leaves that cycle.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_PE; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i_pkt_in[i] && !(hs && grant_q[i])) begin
                if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
                else                     cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!i_pkt_in[i] && hs && grant_q[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        win_d     = win_q;
        grant_d   = grant_q;
        tcnt_d    = tcnt_q;
        timeout_d = 1'b0;
        err_d     = err_q | (i_pkt_done && (state_q != BUSY));
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    win_d   = win_idx;
                    grant_d = NUM_PE'(1) << win_idx;
                end
            end
            GRANT: begin
                // The offer stands regardless of i_pe_en until accepted.
                if (i_grant_ready) begin
                    state_d  = BUSY;
                    rr_ptr_d = (win_q == LAST_PE) ? '0 : win_q + PTR_W'(1);
                    tcnt_d   = '0;
                end
            end
            BUSY: begin
                if (i_pkt_done) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (tcnt_q == TO_LAST) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            ovf_q     <= '0;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            win_q     <= '0;
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < NUM_PE; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ovf_q     <= ovf_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            win_q     <= win_d;
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            for (int i = 0; i < NUM_PE; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // grant_q is still held during BUSY but is only visible while offered.
    assign o_grant_valid = (state_q == GRANT);
    assign o_grant       = o_grant_valid ? grant_q : '0;
    assign o_busy        = (state_q == BUSY);
    assign o_timeout     = timeout_q;
    assign o_ovf         = ovf_q;
    assign o_err         = err_q;
    assign d_state_2b    = state_q;

endmodule

// File: tb/tb_dma_out_sched.sv
module tb_dma_out_sched;

    logic       clk;
    logic       rst_n;
    logic [3:0] pkt_in;
    logic [3:0] pe_en;
    logic       grant_ready;
    logic       pkt_done;
    logic       grant_valid;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;
    logic [3:0] ovf;
    logic       err;
    logic [1:0] dstate;

    int n_cmp = 0;
    int n_bad = 0;

    dma_out_sched #(.NUM_PE(4), .CNT_W(8), .TIMEOUT(16)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pkt_in      (pkt_in),
        .i_pe_en       (pe_en),
        .o_grant_valid (grant_valid),
        .o_grant       (grant),
        .i_grant_ready (grant_ready),
        .i_pkt_done    (pkt_done),
        .o_busy        (busy),
        .o_timeout     (timeout),
        .o_ovf         (ovf),
        .o_err         (err),
        .d_state_2b    (dstate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pkt_in;
        logic       rdy;
        logic       done;
        logic       exp_vld;
        logic [3:0] exp_gnt;
        logic       exp_busy;
        logic       exp_err;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        pkt_in      = '0;
        pe_en       = '0;
        grant_ready = 1'b0;
        pkt_done    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_grant(output logic [3:0] g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int n = 0; n < 50; n++) begin
            if (grant_valid) begin
                g  = grant;
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        logic [3:0] g;
        bit         ok;
        int         n_to;
        int         n_grants;
        int         n_wrong;
        bit         seen;

        // {pkt_in, rdy, done} -> {vld, grant, busy, err} after the next edge
        tbl[0]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0};
        tbl[2]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
        tbl[3]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
        tbl[4]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0};
        tbl[6]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
        tbl[7]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[8]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[9]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
        tbl[10] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};

        // Reset state
        do_reset();
        check("reset_outputs", {grant_valid, grant, busy, timeout, ovf, err, dstate}, '0);

        // Basic two-packet flow, then stray done in IDLE
        pe_en = 4'b1111;
        for (int r = 0; r < 11; r++) begin
            pkt_in      = tbl[r].pkt_in;
            grant_ready = tbl[r].rdy;
            pkt_done    = tbl[r].done;
            tick();
            check($sformatf("vec%0d_vld", r),  grant_valid, tbl[r].exp_vld);
            check($sformatf("vec%0d_gnt", r),  grant,       tbl[r].exp_gnt);
            check($sformatf("vec%0d_busy", r), busy,        tbl[r].exp_busy);
            check($sformatf("vec%0d_err", r),  err,         tbl[r].exp_err);
        end
        check("vec_cnt0_zero", dut.cnt_q[0], 8'd0);
        check("vec_cnt2_zero", dut.cnt_q[2], 8'd0);

        // Round robin between PE0 and PE1, three packets each
        do_reset();
        pkt_in = 4'b0011;
        tick(); tick(); tick();
        pkt_in = '0;
        check("rr_cnt0_load", dut.cnt_q[0], 8'd3);
        check("rr_cnt1_load", dut.cnt_q[1], 8'd3);
        pe_en       = 4'b1111;
        grant_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_grant(g, ok);
            check($sformatf("rr_grant_seen%0d", k), ok, 1'b1);
            check($sformatf("rr_grant%0d", k), g, (k % 2 == 0) ? 4'b0001 : 4'b0010);
            tick();
            pkt_done = 1'b1;
            tick();
            pkt_done = 1'b0;
        end
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (grant_valid) seen = 1'b1;
        end
        check("rr_no_extra_grant", seen, 1'b0);

        // Grant held while the engine is not ready; enable drop must not withdraw it
        do_reset();
        pe_en       = 4'b1111;
        grant_ready = 1'b0;
        pkt_in      = 4'b1000;
        tick();
        pkt_in = '0;
        wait_grant(g, ok);
        check("hold_grant_seen", ok, 1'b1);
        n_wrong = 0;
        for (int n = 0; n < 20; n++) begin
            if (n == 5) pe_en = 4'b0111;
            tick();
            if (!(grant_valid === 1'b1 && grant === 4'b1000 && busy === 1'b0)) n_wrong++;
        end
        check("hold_stable_20", n_wrong, 0);
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        pe_en       = 4'b1111;
        check("hold_handshake", {grant_valid, grant, busy}, {1'b0, 4'b0000, 1'b1});

        // Watchdog abort 16 cycles after the handshake
        n_to = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (timeout) begin
                n_to = n;
                break;
            end
        end
        check("to_cycles", n_to, 16);
        check("to_state", {busy, dstate, grant_valid}, {1'b0, 2'd0, 1'b0});
        tick();
        check("to_pulse_width", timeout, 1'b0);
        check("to_no_err", err, 1'b0);

        // Counter saturation and draining
        do_reset();
        pe_en  = 4'b1011;
        pkt_in = 4'b0100;
        for (int n = 0; n < 256; n++) tick();
        pkt_in = '0;
        check("ovf_cnt2", dut.cnt_q[2], 8'd255);
        check("ovf_flag", ovf, 4'b0100);
        check("ovf_no_grant", grant_valid, 1'b0);
        pe_en       = 4'b1111;
        grant_ready = 1'b1;
        n_grants    = 0;
        n_wrong     = 0;
        for (int k = 0; k < 255; k++) begin
            wait_grant(g, ok);
            if (!ok) begin
                n_wrong++;
                break;
            end
            if (g !== 4'b0100) n_wrong++;
            n_grants++;
            tick();
            pkt_done = 1'b1;
            tick();
            pkt_done = 1'b0;
        end
        check("ovf_grant_count", n_grants, 255);
        check("ovf_grant_wrong", n_wrong, 0);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (grant_valid) seen = 1'b1;
        end
        check("ovf_drained", seen, 1'b0);
        check("ovf_sticky", ovf, 4'b0100);

        // Asynchronous reset in the middle of a packet
        do_reset();
        pkt_in = 4'b1000;
        for (int n = 0; n < 6; n++) tick();
        pkt_in      = '0;
        pe_en       = 4'b1000;
        grant_ready = 1'b1;
        wait_grant(g, ok);
        check("arst_grant", g, 4'b1000);
        tick();
        check("arst_busy", busy, 1'b1);
        check("arst_cnt3_before", dut.cnt_q[3], 8'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_outputs", {grant_valid, grant, busy, timeout, ovf, err, dstate}, '0);
        check("arst_cnt3", dut.cnt_q[3], 8'd0);
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (grant_valid || busy) seen = 1'b1;
        end
        check("arst_no_grant_after", seen, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
